// File: rtl/strip_coord_pkg.sv
// Shared types and constants for the strip-coordinate table and its scan sequencer.
// Holds the scan state enum, the legacy 13-strip layout and the saturating height helper.
package strip_coord_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DONE    = 2'd2
    } scan_state_t;

    // Legacy strip layout for a 128-row image split into 13 strips.
    localparam int DEFAULT_Y13 [13] = '{0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};

    function automatic int reset_y(input int idx, input int num, input int img_h);
        if (num == 13) begin
            return DEFAULT_Y13[idx];
        end
        return idx * (img_h / num);
    endfunction

    // A non-monotonic table would give a negative height; clamp it to zero.
    function automatic int sat_height(input int y_top, input int y_next);
        return (y_next > y_top) ? (y_next - y_top) : 0;
    endfunction

endpackage

// File: rtl/strip_coord_regfile.sv
// Strip y-coordinate storage: one write port and two combinational read ports, each
// returning the entry and the following strip's top (image height for the last strip).
module strip_coord_regfile
    import strip_coord_pkg::*;
#(
    parameter int NUM_STRIPS = 13,
    parameter int ID_W       = 4,
    parameter int Y_W        = 7,
    parameter int IMG_H      = 128
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wr_en,
    input  logic [ID_W-1:0] i_wr_addr,
    input  logic [Y_W-1:0]  i_wr_data,
    input  logic [ID_W-1:0] i_rda_addr,
    output logic [Y_W-1:0]  o_rda_y,
    output logic [Y_W:0]    o_rda_ynext,
    input  logic [ID_W-1:0] i_rdb_addr,
    output logic [Y_W-1:0]  o_rdb_y,
    output logic [Y_W:0]    o_rdb_ynext
);

    localparam logic [ID_W:0]   LP_NUM  = (ID_W+1)'(NUM_STRIPS);
    localparam logic [ID_W-1:0] LP_LAST = ID_W'(NUM_STRIPS - 1);
    localparam logic [Y_W:0]    LP_IMGH = (Y_W+1)'(IMG_H);

    logic [Y_W-1:0] r_table [NUM_STRIPS];

    // The write enable arrives already qualified (in range, no scan running).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
                r_table[i] <= Y_W'(reset_y(i, NUM_STRIPS, IMG_H));
            end
        end else if (i_wr_en) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_rda_y     = '0;
        o_rda_ynext = '0;
        if ({1'b0, i_rda_addr} < LP_NUM) begin
            o_rda_y = r_table[i_rda_addr];
            if (i_rda_addr == LP_LAST) begin
                o_rda_ynext = LP_IMGH;
            end else begin
                o_rda_ynext = {1'b0, r_table[i_rda_addr + ID_W'(1)]};
            end
        end
    end

    always_comb begin
        o_rdb_y     = '0;
        o_rdb_ynext = '0;
        if ({1'b0, i_rdb_addr} < LP_NUM) begin
            o_rdb_y = r_table[i_rdb_addr];
            if (i_rdb_addr == LP_LAST) begin
                o_rdb_ynext = LP_IMGH;
            end else begin
                o_rdb_ynext = {1'b0, r_table[i_rdb_addr + ID_W'(1)]};
            end
        end
    end

endmodule

// File: rtl/strip_coord_seq.sv
// Strip-coordinate table with random lookup and a valid/ready strip sequencer that
// streams (id, y, height) for every strip in order.
module strip_coord_seq
    import strip_coord_pkg::*;
#(
    parameter int NUM_STRIPS = 13,
    parameter int ID_W       = 4,
    parameter int Y_W        = 7,
    parameter int IMG_H      = 128
) (
    input  logic            enclk,
    input  logic            rst,
    input  logic            lk_en,
    input  logic [ID_W-1:0] lk_addr,
    output logic [Y_W-1:0]  lk_y,
    output logic [Y_W:0]    lk_h,
    output logic            lk_valid,
    output logic            lk_err,
    input  logic            wr_en,
    input  logic [ID_W-1:0] wr_addr,
    input  logic [Y_W-1:0]  wr_data,
    output logic            wr_err,
    input  logic            scan_start,
    output logic            scan_busy,
    output logic            scan_done,
    output logic            s_valid,
    input  logic            s_ready,
    output logic [ID_W-1:0] s_id,
    output logic [Y_W-1:0]  s_y,
    output logic [Y_W:0]    s_h
);

    localparam logic [ID_W:0]   LP_NUM  = (ID_W+1)'(NUM_STRIPS);
    localparam logic [ID_W-1:0] LP_LAST = ID_W'(NUM_STRIPS - 1);

    scan_state_t     r_state;
    scan_state_t     w_next_state;
    logic [ID_W-1:0] r_idx;
    logic [Y_W-1:0]  r_s_y;
    logic [Y_W:0]    r_s_h;
    logic [Y_W-1:0]  r_lk_y;
    logic [Y_W:0]    r_lk_h;
    logic            r_lk_valid;
    logic            r_lk_err;
    logic            r_wr_err;

    logic            w_s_valid;
    logic            w_scan_busy;
    logic            w_scan_done;
    logic            w_lk_in_range;
    logic            w_wr_accept;
    logic            w_load_item;
    logic [ID_W-1:0] w_sc_addr;
    logic [Y_W-1:0]  w_lk_y;
    logic [Y_W:0]    w_lk_ynext;
    logic [Y_W:0]    w_lk_h;
    logic [Y_W-1:0]  w_sc_y;
    logic [Y_W:0]    w_sc_ynext;
    logic [Y_W:0]    w_sc_h;

    strip_coord_regfile #(
        .NUM_STRIPS (NUM_STRIPS),
        .ID_W       (ID_W),
        .Y_W        (Y_W),
        .IMG_H      (IMG_H)
    ) u_regfile (
        .i_clk       (enclk),
        .i_rst_n     (rst),
        .i_wr_en     (w_wr_accept),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rda_addr  (lk_addr),
        .o_rda_y     (w_lk_y),
        .o_rda_ynext (w_lk_ynext),
        .i_rdb_addr  (w_sc_addr),
        .o_rdb_y     (w_sc_y),
        .o_rdb_ynext (w_sc_ynext)
    );

    assign w_lk_h = (Y_W+1)'(sat_height(int'(w_lk_y), int'(w_lk_ynext)));
    assign w_sc_h = (Y_W+1)'(sat_height(int'(w_sc_y), int'(w_sc_ynext)));

    assign w_lk_in_range = ({1'b0, lk_addr} < LP_NUM);
    assign w_wr_accept   = wr_en && ({1'b0, wr_addr} < LP_NUM) && !w_scan_busy;

    // Port B points at the item that gets registered on the next load edge.
    always_comb begin
        w_sc_addr   = '0;
        w_load_item = 1'b0;
        if (r_state == PRESENT) begin
            w_sc_addr   = r_idx + ID_W'(1);
            w_load_item = s_ready && (r_idx != LP_LAST);
        end else if (r_state == IDLE) begin
            w_load_item = scan_start;
        end
    end

    always_ff @(posedge enclk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (scan_start) w_next_state = PRESENT;
            PRESENT: if (s_ready && (r_idx == LP_LAST)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_s_valid   = 1'b0;
        w_scan_busy = 1'b0;
        w_scan_done = 1'b0;
        case (r_state)
            PRESENT: begin
                w_s_valid   = 1'b1;
                w_scan_busy = 1'b1;
            end
            DONE:    w_scan_done = 1'b1;
            default: ;
        endcase
    end

    // Stream item registers only change on a load, so a stalled item stays stable.
    always_ff @(posedge enclk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
            r_s_y <= '0;
            r_s_h <= '0;
        end else if (w_load_item) begin
            r_idx <= w_sc_addr;
            r_s_y <= w_sc_y;
            r_s_h <= w_sc_h;
        end
    end

    always_ff @(posedge enclk or negedge rst) begin
        if (!rst) begin
            r_lk_y     <= '0;
            r_lk_h     <= '0;
            r_lk_valid <= 1'b0;
            r_lk_err   <= 1'b0;
        end else begin
            r_lk_valid <= lk_en;
            r_lk_err   <= lk_en && !w_lk_in_range;
            if (lk_en) begin
                r_lk_y <= w_lk_in_range ? w_lk_y : '0;
                r_lk_h <= w_lk_in_range ? w_lk_h : '0;
            end
        end
    end

    always_ff @(posedge enclk or negedge rst) begin
        if (!rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_accept;
        end
    end

    assign lk_y      = r_lk_y;
    assign lk_h      = r_lk_h;
    assign lk_valid  = r_lk_valid;
    assign lk_err    = r_lk_err;
    assign wr_err    = r_wr_err;
    assign scan_busy = w_scan_busy;
    assign scan_done = w_scan_done;
    assign s_valid   = w_s_valid;
    assign s_id      = r_idx;
    assign s_y       = r_s_y;
    assign s_h       = r_s_h;

endmodule

// File: tb/tb_strip_coord_seq.sv
// Scoreboard bench for strip_coord_seq: a table model predicts lookups and scan items,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_strip_coord_seq;

    localparam int NUM_STRIPS = 13;
    localparam int ID_W       = 4;
    localparam int Y_W        = 7;
    localparam int IMG_H      = 128;

    logic            enclk      = 1'b0;
    logic            rst        = 1'b1;
    logic            lk_en      = 1'b0;
    logic [ID_W-1:0] lk_addr    = '0;
    logic            wr_en      = 1'b0;
    logic [ID_W-1:0] wr_addr    = '0;
    logic [Y_W-1:0]  wr_data    = '0;
    logic            scan_start = 1'b0;
    logic            s_ready    = 1'b0;
    logic [Y_W-1:0]  lk_y;
    logic [Y_W:0]    lk_h;
    logic            lk_valid;
    logic            lk_err;
    logic            wr_err;
    logic            scan_busy;
    logic            scan_done;
    logic            s_valid;
    logic [ID_W-1:0] s_id;
    logic [Y_W-1:0]  s_y;
    logic [Y_W:0]    s_h;

    strip_coord_seq #(
        .NUM_STRIPS (NUM_STRIPS),
        .ID_W       (ID_W),
        .Y_W        (Y_W),
        .IMG_H      (IMG_H)
    ) dut (
        .enclk      (enclk),
        .rst        (rst),
        .lk_en      (lk_en),
        .lk_addr    (lk_addr),
        .lk_y       (lk_y),
        .lk_h       (lk_h),
        .lk_valid   (lk_valid),
        .lk_err     (lk_err),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_id       (s_id),
        .s_y        (s_y),
        .s_h        (s_h)
    );

    always #5 enclk = ~enclk;

    typedef struct { int id; int y; int h; } item_t;
    typedef struct { int y; int h; int err; } look_t;

    item_t scanQ [$];
    look_t lookQ [$];
    int    modelY [NUM_STRIPS];
    int    checks = 0;
    int    fails  = 0;
    bit    stalled = 1'b0;
    int    heldId, heldY, heldH;
    item_t expItem;
    look_t expLook;

    function automatic void resetModel();
        int def13 [13] = '{0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};
        for (int i = 0; i < NUM_STRIPS; i++) begin
            modelY[i] = (NUM_STRIPS == 13) ? def13[i] : i * (IMG_H / NUM_STRIPS);
        end
    endfunction

    function automatic int modelH(input int i);
        int below;
        below = (i == NUM_STRIPS - 1) ? IMG_H : modelY[i + 1];
        return (below >= modelY[i]) ? below - modelY[i] : 0;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_lk_y"}, int'(lk_y), 0);
        checkOutput({tag, "_lk_h"}, int'(lk_h), 0);
        checkOutput({tag, "_lk_valid"}, int'(lk_valid), 0);
        checkOutput({tag, "_lk_err"}, int'(lk_err), 0);
        checkOutput({tag, "_wr_err"}, int'(wr_err), 0);
        checkOutput({tag, "_scan_busy"}, int'(scan_busy), 0);
        checkOutput({tag, "_scan_done"}, int'(scan_done), 0);
        checkOutput({tag, "_s_valid"}, int'(s_valid), 0);
        checkOutput({tag, "_s_id"}, int'(s_id), 0);
        checkOutput({tag, "_s_y"}, int'(s_y), 0);
        checkOutput({tag, "_s_h"}, int'(s_h), 0);
    endtask

    // One clock of stimulus; busy says whether the bench expects a scan to be running.
    task automatic applyStimulus(input bit lkEn, input int lkAddr, input bit wrEn,
                                 input int wrAddr, input int wrData, input bit busy);
        bit wrOk;
        lk_en   = lkEn;
        lk_addr = ID_W'(lkAddr);
        wr_en   = wrEn;
        wr_addr = ID_W'(wrAddr);
        wr_data = Y_W'(wrData);
        if (lkEn) begin
            if (lkAddr < NUM_STRIPS) lookQ.push_back('{modelY[lkAddr], modelH(lkAddr), 0});
            else                     lookQ.push_back('{0, 0, 1});
        end
        wrOk = wrEn && (wrAddr < NUM_STRIPS) && !busy;
        @(posedge enclk);
        if (wrOk) modelY[wrAddr] = wrData;
        #1;
        checkOutput("wr_err", int'(wr_err), int'(wrEn && !wrOk));
        lk_en = 1'b0;
        wr_en = 1'b0;
    endtask

    // mode 0: ready always high, 1: alternating, 2: random
    task automatic runScan(input int mode, input bit midWrite, input bit midRestart);
        int hs = 0;
        int cycles = 0;
        for (int i = 0; i < NUM_STRIPS; i++) scanQ.push_back('{i, modelY[i], modelH(i)});
        scan_start = 1'b1;
        s_ready    = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
        scan_start = 1'b0;
        checkOutput("scan_busy_rise", int'(scan_busy), 1);
        checkOutput("s_valid_rise", int'(s_valid), 1);
        while (hs < NUM_STRIPS && cycles < 20 * NUM_STRIPS) begin
            case (mode)
                0:       s_ready = 1'b1;
                1:       s_ready = (cycles % 2 == 1);
                default: s_ready = ($urandom % 2 == 1);
            endcase
            scan_start = midRestart && (hs == 3);
            applyStimulus($urandom % 2 == 1, $urandom % 16, midWrite && (hs == 5),
                          $urandom % NUM_STRIPS, $urandom % 128, 1'b1);
            if (s_ready) hs++;
            cycles++;
        end
        scan_start = 1'b0;
        if (hs < NUM_STRIPS) checkOutput("scan_timeout", hs, NUM_STRIPS);
        checkOutput("scan_done", int'(scan_done), 1);
        checkOutput("busy_in_done", int'(scan_busy), 0);
        checkOutput("s_valid_in_done", int'(s_valid), 0);
        if (mode == 0) checkOutput("scan_cycles", cycles, NUM_STRIPS);
        s_ready = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
        checkOutput("scan_done_pulse", int'(scan_done), 0);
        checkOutput("scan_items_left", scanQ.size(), 0);
    endtask

    // Monitor: stall stability first, then handshake and lookup scoreboards.
    always @(negedge enclk) begin
        if (rst) begin
            if (stalled) begin
                checkOutput("stall_valid", int'(s_valid), 1);
                checkOutput("stall_id", int'(s_id), heldId);
                checkOutput("stall_y", int'(s_y), heldY);
                checkOutput("stall_h", int'(s_h), heldH);
            end
            stalled = 1'b0;
            if (s_valid && s_ready) begin
                if (scanQ.size() == 0) begin
                    checkOutput("scan_unexpected", 1, 0);
                end else begin
                    expItem = scanQ.pop_front();
                    checkOutput("s_id", int'(s_id), expItem.id);
                    checkOutput("s_y", int'(s_y), expItem.y);
                    checkOutput("s_h", int'(s_h), expItem.h);
                end
            end else if (s_valid) begin
                stalled = 1'b1;
                heldId  = int'(s_id);
                heldY   = int'(s_y);
                heldH   = int'(s_h);
            end
            if (lk_valid) begin
                if (lookQ.size() == 0) begin
                    checkOutput("lk_unexpected", 1, 0);
                end else begin
                    expLook = lookQ.pop_front();
                    checkOutput("lk_y", int'(lk_y), expLook.y);
                    checkOutput("lk_h", int'(lk_h), expLook.h);
                    checkOutput("lk_err", int'(lk_err), expLook.err);
                end
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        resetModel();
        #3 rst = 1'b0;
        #1 checkAllZero("reset");
        #20;
        @(negedge enclk) rst = 1'b1;
        @(posedge enclk);
        #1;

        applyStimulus(1'b1, 5, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 12, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 13, 1'b1, 14, 77, 1'b0);
        applyStimulus(1'b1, 15, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 3, 24, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 3, 1'b1, 4, 10, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, 4, 1'b0, 0, 0, 1'b0);

        runScan(0, 1'b0, 1'b0);
        runScan(1, 1'b1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            int a;
            a = $urandom % 16;
            applyStimulus($urandom % 2 == 1, a, $urandom % 3 == 0,
                          ($urandom % 4 == 0) ? a : $urandom % 16, $urandom % 128, 1'b0);
        end

        runScan(2, 1'b1, 1'b0);

        for (int i = 0; i < NUM_STRIPS; i++) scanQ.push_back('{i, modelY[i], modelH(i)});
        scan_start = 1'b1;
        s_ready    = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
        scan_start = 1'b0;
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b1);
        checkOutput("s_id_before_reset", int'(s_id), 6);
        rst = 1'b0;
        #1 checkAllZero("midscan_reset");
        scanQ.delete();
        lookQ.delete();
        resetModel();
        s_ready = 1'b0;
        repeat (2) @(posedge enclk);
        @(negedge enclk) rst = 1'b1;
        @(posedge enclk);
        #1;
        checkOutput("no_done_after_reset", int'(scan_done), 0);
        applyStimulus(1'b1, 3, 1'b0, 0, 0, 1'b0);
        checkOutput("lk3_after_reset", int'(lk_y), 25);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
        runScan(0, 1'b0, 1'b0);

        repeat (2) applyStimulus(1'b0, 0, 1'b0, 0, 0, 1'b0);
        checkOutput("lookups_left", lookQ.size(), 0);
        checkOutput("items_left", scanQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/strip_coord_seq.md
# strip_coord_seq

Parametrised strip-coordinate table with a built-in strip sequencer. It holds the top y-coordinate of every horizontal image strip and derives each strip's height. Two access paths: random lookup by strip id, and a scan that streams (id, y, height) for every strip over a valid/ready handshake. It feeds the per-strip processing datapath and replaces the fixed 13-entry strip-id to y lookup.

## Interface
- `NUM_STRIPS`, default 13: number of strips, 2..2^ID_W.
- `ID_W`, default 4: strip-id width.
- `Y_W`, default 7: y-coordinate width.
- `IMG_H`, default 128: image height in rows, at most 2^Y_W.
- `enclk` in, 1: clock, rising edge.
- `rst` in, 1: reset, asynchronous, active-low (asserted at 0).
- `lk_en` in, 1: lookup request.
- `lk_addr` in, ID_W: strip id to look up.
- `lk_y` out, Y_W: looked-up y.
- `lk_h` out, Y_W+1: looked-up height.
- `lk_valid` out, 1: lookup result valid.
- `lk_err` out, 1: lookup address out of range.
- `wr_en` in, 1: table write.
- `wr_addr` in, ID_W: table write address.
- `wr_data` in, Y_W: new y value.
- `wr_err` out, 1: write rejected.
- `scan_start` in, 1: start a scan.
- `scan_busy` out, 1: scan in progress.
- `scan_done` out, 1: one-cycle pulse when a scan completes.
- `s_valid` out, 1: stream item valid.
- `s_ready` in, 1: consumer ready.
- `s_id` out, ID_W: stream strip id.
- `s_y` out, Y_W: stream y.
- `s_h` out, Y_W+1: stream height.

## Operation
- **Reset contents.**
  - When NUM_STRIPS==13, the table resets to 0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112.
  - Otherwise entry i resets to i*(IMG_H/NUM_STRIPS), using integer division.
- **Height.**
  - h[i] = y[i+1] − y[i] for i < NUM_STRIPS−1.
  - h[NUM_STRIPS−1] = IMG_H − y[NUM_STRIPS−1].
  - Computed in Y_W+1 bits. A negative result (non-monotonic table) saturates to 0.
- **Lookup.**
  - `lk_en` with `lk_addr` < NUM_STRIPS registers `lk_y` and `lk_h`, and `lk_valid` = 1 for one cycle.
  - An out-of-range address gives `lk_y` = 0, `lk_h` = 0, `lk_valid` = 1, `lk_err` = 1.
  - Without `lk_en`, `lk_valid` and `lk_err` are 0 and `lk_y`/`lk_h` hold.
  - Lookups are served in every state, including during a scan.
- **Write.**
  - Accepted when `wr_en`, `wr_addr` < NUM_STRIPS and `scan_busy` = 0.
  - An out-of-range address, or a write while busy, is dropped and pulses `wr_err` for one cycle.
  - A lookup in the same cycle as a write to the same entry returns the old value (read-before-write).
- **Scan FSM** (states IDLE, PRESENT, DONE):
  - IDLE: `scan_start` loads idx = 0, registers item 0, goes to PRESENT.
  - PRESENT: `s_valid` = 1 and `scan_busy` = 1. On `s_valid && s_ready`:
    - If idx == NUM_STRIPS−1, go to DONE with `s_valid` = 0.
    - Otherwise idx increments and the next item is registered on the same edge, so back-to-back items are possible.
  - PRESENT with `s_ready` = 0: all `s_*` outputs hold stable.
  - DONE: `scan_done` = 1 for one cycle, `scan_busy` = 0, then IDLE.
  - `scan_start` outside IDLE is ignored.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - idx = 0.
  - Table holds its reset contents.
- Lookup latency: 1 cycle (request at edge k, result visible after edge k+1).
- Scan timing:
  - `s_valid` rises 1 cycle after `scan_start`.
  - With `s_ready` held high, one item per cycle.
  - `scan_done` is asserted the cycle after the last handshake.
  - Start to `scan_done` is NUM_STRIPS+1 cycles minimum.
- Reset asserted mid-scan:
  - Outputs and FSM clear immediately (asynchronous).
  - Table returns to its reset contents.
  - No `scan_done` is issued.

## Structure
- Package `strip_coord_pkg` holds:
  - the state enum (IDLE, PRESENT, DONE);
  - the default 13-entry table constant;
  - a height function with saturation.
- Sub-module `strip_coord_regfile` holds:
  - table storage with reset initialisation;
  - one write port;
  - two combinational read ports, each returning y[i] and y[i+1] (or IMG_H for the last entry).
- The top level holds the lookup register, the scan FSM, and the height subtractors.

## Test plan
- After reset, lookup `lk_addr` = 5 → next cycle `lk_y` = 42, `lk_h` = 6, `lk_valid` = 1, `lk_err` = 0. Lookup 12 → `lk_y` = 112, `lk_h` = 16.
- Lookup `lk_addr` = 13 → `lk_y` = 0, `lk_h` = 0, `lk_err` = 1. Write `wr_addr` = 14 → `wr_err` pulse, table unchanged.
- Write entry 3 = 24, then lookup 2 → `lk_h` = 8; lookup 3 → `lk_h` = 8. Write entry 4 = 10, then lookup 3 → `lk_h` = 0 (saturated).
- Scan with `s_ready` = 1 → `s_id` 0..12 on 13 consecutive cycles, `s_y`/`s_h` match the table, `scan_done` pulse 14 cycles after start.
- Scan with `s_ready` toggling 1/0 → each item held stable while stalled, no skipped or duplicated id. A write during the scan → `wr_err` = 1, table unchanged. A second `scan_start` mid-scan is ignored.
- Assert `rst` low at item 6 → all outputs 0 immediately. After release, lookup 3 returns 25 and a fresh scan starts at id 0.
